// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch front end between the PC stage and decode.
// Issues one imem request at a time and fills the IF/ID register.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module if_fetch_unit #(
    parameter int unsigned    W        = `WORD_WIDTH,
    parameter logic [W-1:0]   NOP_INST = W'(32'h0000_0000)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] pc,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [W-1:0] imem_addr,
    input  logic         imem_resp_valid,
    input  logic [W-1:0] imem_resp_data,
    input  logic         stall_in,
    input  logic         flush,
    output logic         fetch_stall,
    output logic         id_valid,
    output logic [W-1:0] id_pc,
    output logic [W-1:0] id_inst
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] addr_q, addr_d;
    logic [W-1:0] skid_q, skid_d;
    logic         id_valid_q, id_valid_d;
    logic [W-1:0] id_pc_q, id_pc_d;
    logic [W-1:0] id_inst_q, id_inst_d;

    logic         accept;
    logic         commit;
    logic [W-1:0] commit_inst;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_REQ;
            addr_q     <= '0;
            skid_q     <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_inst_q  <= NOP_INST;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            skid_q     <= skid_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
        end
    end

    // Next-state: a flush while a response is still owed sends us to DROP
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ: begin
                if (imem_req_ready)
                    state_d = flush ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (flush || !stall_in)
                        state_d = S_REQ;
                    else
                        state_d = S_HOLD;
                end else if (flush) begin
                    state_d = S_DROP;
                end
            end
            S_HOLD: begin
                if (flush || !stall_in)
                    state_d = S_REQ;
            end
            S_DROP: begin
                if (imem_resp_valid)
                    state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    // Outputs, request capture, skid buffer and IF/ID register update
    always_comb begin
        imem_req_valid = (state_q == S_REQ);
        imem_addr      = pc;
        accept         = imem_req_valid && imem_req_ready;

        commit = !flush && !stall_in &&
                 (((state_q == S_WAIT) && imem_resp_valid) ||
                  (state_q == S_HOLD));
        commit_inst = (state_q == S_HOLD) ? skid_q : imem_resp_data;

        fetch_stall = !(commit || flush);

        addr_d = accept ? pc : addr_q;

        skid_d = skid_q;
        if ((state_q == S_WAIT) && imem_resp_valid && !flush && stall_in)
            skid_d = imem_resp_data;

        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        if (flush) begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
        end else if (commit) begin
            id_valid_d = 1'b1;
            id_pc_d    = addr_q;
            id_inst_d  = commit_inst;
        end else if (!stall_in) begin
            id_valid_d = 1'b0;
        end
    end

    assign id_valid = id_valid_q;
    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed and random checks of the fetch front end
// against a transaction-level model and a random-latency memory.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        stall_in;
    logic        flush;
    logic        fetch_stall;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    if_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .stall_in        (stall_in),
        .flush           (flush),
        .fetch_stall     (fetch_stall),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_inst         (id_inst)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // memory model: one outstanding request, response after mem_lat cycles
    bit          mem_pend = 0;
    int          mem_due  = 0;
    logic [31:0] mem_data = 0;
    int          mem_lat  = 1;
    bit          mem_force = 0;
    logic [31:0] mem_force_data = 0;

    // transaction-level reference model
    bit          m_await = 0, m_doomed = 0, m_held = 0;
    logic [31:0] m_req_addr = 0, m_hdata = 0;
    bit          e_idv = 0, e_rv = 0, e_fs = 0, e_commit = 0;
    logic [31:0] e_pc = 0, e_inst = 0;

    // sampled DUT values
    bit          s_fs, s_rv;
    logic [31:0] s_addr, s_pc;
    bit          a_idv;
    logic [31:0] a_pc, a_inst;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic step(input bit st, input bit fl, input bit rdy,
                        input logic [31:0] tgt);
        bit          acc, rsp, held_old;
        logic [31:0] rdata;
        stall_in       = st;
        flush          = fl;
        imem_req_ready = rdy;
        rsp = mem_pend && (cyc == mem_due);
        if (rsp) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_data;
            mem_pend        = 1'b0;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        rdata = imem_resp_data;
        #1;
        s_fs   = fetch_stall;
        s_rv   = imem_req_valid;
        s_addr = imem_addr;
        s_pc   = pc;
        // expected behaviour this cycle
        e_rv     = !m_await && !m_held;
        e_commit = !fl && !st &&
                   ((m_await && !m_doomed && rsp) || m_held);
        e_fs     = !(e_commit || fl);
        if (fl) begin
            e_idv  = 1'b0;
            e_inst = 32'h0;
        end else if (e_commit) begin
            e_idv  = 1'b1;
            e_pc   = m_req_addr;
            e_inst = m_held ? m_hdata : rdata;
        end else if (!st) begin
            e_idv = 1'b0;
        end
        // transaction bookkeeping
        acc      = e_rv && rdy;
        held_old = m_held;
        if (held_old && (fl || !st))
            m_held = 1'b0;
        if (m_await && rsp) begin
            m_await = 1'b0;
            if (!m_doomed && !fl && st) begin
                m_held  = 1'b1;
                m_hdata = rdata;
            end
        end else if (m_await && fl) begin
            m_doomed = 1'b1;
        end
        if (acc) begin
            m_await    = 1'b1;
            m_doomed   = fl;
            m_req_addr = s_pc;
        end
        // memory accepts whatever the DUT actually requests
        if (s_rv && rdy) begin
            mem_pend = 1'b1;
            mem_due  = cyc + mem_lat;
            mem_data = mem_force ? mem_force_data : mem_f(s_addr);
        end
        @(posedge clk);
        cyc++;
        #1;
        if (!s_fs)
            pc = fl ? tgt : pc + 32'd4;
        @(negedge clk);
        a_idv  = id_valid;
        a_pc   = id_pc;
        a_inst = id_inst;
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 20; i++) begin
            if (!m_await && !m_held) begin
                done = 1;
                break;
            end
            step(0, 0, 0, 0);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain: transaction still open after 20 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; pc = 32'h100; flush = 0; stall_in = 0;
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks += 5;
        if (id_valid !== 1'b0) begin errors++;
            $display("FAIL reset id_valid: got %b want 0", id_valid); end
        if (id_inst !== 32'h0) begin errors++;
            $display("FAIL reset id_inst: got %h want 0", id_inst); end
        if (imem_req_valid !== 1'b1) begin errors++;
            $display("FAIL reset req_valid: got %b want 1", imem_req_valid); end
        if (imem_addr !== 32'h100) begin errors++;
            $display("FAIL reset addr: got %h want 100", imem_addr); end
        if (fetch_stall !== 1'b1) begin errors++;
            $display("FAIL reset fetch_stall: got %b want 1", fetch_stall); end
    endtask

    task automatic test_basic();
        pc = 32'h0; mem_lat = 1; mem_force = 1;
        mem_force_data = 32'h2408_0005;
        step(0, 0, 1, 0);
        checks += 3;
        if (s_rv !== 1'b1) begin errors++;
            $display("FAIL basic req_valid: got %b want 1", s_rv); end
        if (s_addr !== 32'h0) begin errors++;
            $display("FAIL basic addr: got %h want 0", s_addr); end
        if (s_fs !== 1'b1) begin errors++;
            $display("FAIL basic stall_req: got %b want 1", s_fs); end
        step(0, 0, 0, 0);
        checks += 4;
        if (s_fs !== 1'b0) begin errors++;
            $display("FAIL basic stall_commit: got %b want 0", s_fs); end
        if (a_idv !== 1'b1) begin errors++;
            $display("FAIL basic id_valid: got %b want 1", a_idv); end
        if (a_pc !== 32'h0) begin errors++;
            $display("FAIL basic id_pc: got %h want 0", a_pc); end
        if (a_inst !== 32'h2408_0005) begin errors++;
            $display("FAIL basic id_inst: got %h want 24080005", a_inst); end
        step(0, 0, 0, 0);
        checks += 3;
        if (s_fs !== 1'b1) begin errors++;
            $display("FAIL basic stall_after: got %b want 1", s_fs); end
        if (s_addr !== 32'h4) begin errors++;
            $display("FAIL basic next_addr: got %h want 4", s_addr); end
        if (a_idv !== 1'b0) begin errors++;
            $display("FAIL basic bubble: got %b want 0", a_idv); end
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] p_pc, p_inst;
        pc = 32'h8; p_pc = a_pc; p_inst = a_inst;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            checks += 5;
            if (s_rv !== 1'b1) begin errors++;
                $display("FAIL bp req_valid: got %b want 1", s_rv); end
            if (s_addr !== 32'h8) begin errors++;
                $display("FAIL bp addr: got %h want 8", s_addr); end
            if (s_fs !== 1'b1) begin errors++;
                $display("FAIL bp fetch_stall: got %b want 1", s_fs); end
            if (a_pc !== p_pc) begin errors++;
                $display("FAIL bp id_pc: got %h want %h", a_pc, p_pc); end
            if (a_inst !== p_inst) begin errors++;
                $display("FAIL bp id_inst: got %h want %h", a_inst, p_inst); end
        end
        step(0, 0, 1, 0);
        drain();
    endtask

    task automatic test_decode_stall();
        logic [31:0] p_pc, p_inst;
        bit          p_v;
        pc = 32'hC; mem_lat = 1; mem_force_data = 32'hAAAA_0001;
        step(0, 0, 1, 0);
        p_pc = a_pc; p_inst = a_inst; p_v = a_idv;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            checks += 4;
            if (s_fs !== 1'b1) begin errors++;
                $display("FAIL dstall fetch_stall: got %b want 1", s_fs); end
            if (a_inst !== p_inst) begin errors++;
                $display("FAIL dstall id_inst: got %h want %h", a_inst, p_inst); end
            if (a_pc !== p_pc) begin errors++;
                $display("FAIL dstall id_pc: got %h want %h", a_pc, p_pc); end
            if (a_idv !== p_v) begin errors++;
                $display("FAIL dstall id_valid: got %b want %b", a_idv, p_v); end
        end
        step(0, 0, 0, 0);
        checks += 4;
        if (s_fs !== 1'b0) begin errors++;
            $display("FAIL dstall release: got %b want 0", s_fs); end
        if (a_inst !== 32'hAAAA_0001) begin errors++;
            $display("FAIL dstall inst: got %h want aaaa0001", a_inst); end
        if (a_pc !== 32'hC) begin errors++;
            $display("FAIL dstall pc: got %h want c", a_pc); end
        if (a_idv !== 1'b1) begin errors++;
            $display("FAIL dstall valid: got %b want 1", a_idv); end
        step(0, 0, 0, 0);
        checks++;
        if (s_fs !== 1'b1) begin errors++;
            $display("FAIL dstall one_cycle: got %b want 1", s_fs); end
        drain();
    endtask

    task automatic test_flush_inflight();
        bit back = 0;
        pc = 32'h10; mem_lat = 3; mem_force_data = 32'hDEAD_BEEF;
        step(0, 0, 1, 0);
        step(0, 1, 0, 32'h40);
        checks += 3;
        if (s_fs !== 1'b0) begin errors++;
            $display("FAIL fif fetch_stall: got %b want 0", s_fs); end
        if (a_idv !== 1'b0) begin errors++;
            $display("FAIL fif id_valid: got %b want 0", a_idv); end
        if (a_inst !== 32'h0) begin errors++;
            $display("FAIL fif id_inst: got %h want 0", a_inst); end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0);
            if (s_rv) begin
                back = 1;
                break;
            end
            checks += 2;
            if (a_inst === 32'hDEAD_BEEF) begin errors++;
                $display("FAIL fif leak: got %h want not deadbeef", a_inst); end
            if (a_idv !== 1'b0) begin errors++;
                $display("FAIL fif drop_valid: got %b want 0", a_idv); end
        end
        checks += 2;
        if (!back) begin errors++;
            $display("FAIL fif timeout: got no request want request"); end
        if (s_addr !== 32'h40) begin errors++;
            $display("FAIL fif target: got %h want 40", s_addr); end
        drain();
    endtask

    task automatic test_flush_coincident();
        pc = 32'h20; mem_lat = 2; mem_force_data = 32'h1111_2222;
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 32'h80);
        checks += 3;
        if (s_fs !== 1'b0) begin errors++;
            $display("FAIL fco fetch_stall: got %b want 0", s_fs); end
        if (a_idv !== 1'b0) begin errors++;
            $display("FAIL fco id_valid: got %b want 0", a_idv); end
        if (a_inst !== 32'h0) begin errors++;
            $display("FAIL fco id_inst: got %h want 0", a_inst); end
        step(0, 0, 0, 0);
        checks += 2;
        if (s_rv !== 1'b1) begin errors++;
            $display("FAIL fco req: got %b want 1", s_rv); end
        if (s_addr !== 32'h80) begin errors++;
            $display("FAIL fco addr: got %h want 80", s_addr); end
        drain();
    endtask

    task automatic test_flush_hold();
        pc = 32'h30; mem_lat = 1; mem_force_data = 32'h3333_4444;
        step(0, 0, 1, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 32'h90);
        checks += 3;
        if (s_fs !== 1'b0) begin errors++;
            $display("FAIL fho fetch_stall: got %b want 0", s_fs); end
        if (a_idv !== 1'b0) begin errors++;
            $display("FAIL fho id_valid: got %b want 0", a_idv); end
        if (a_inst !== 32'h0) begin errors++;
            $display("FAIL fho id_inst: got %h want 0", a_inst); end
        step(0, 0, 0, 0);
        checks += 4;
        if (s_rv !== 1'b1) begin errors++;
            $display("FAIL fho req: got %b want 1", s_rv); end
        if (s_addr !== 32'h90) begin errors++;
            $display("FAIL fho addr: got %h want 90", s_addr); end
        if (s_fs !== 1'b1) begin errors++;
            $display("FAIL fho stall: got %b want 1", s_fs); end
        if (a_inst !== 32'h0) begin errors++;
            $display("FAIL fho leak: got %h want 0", a_inst); end
        drain();
    endtask

    task automatic test_back_to_back();
        int          n = 0;
        logic [31:0] want = 32'h200;
        pc = 32'h200; mem_lat = 1; mem_force = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 0);
            if (!s_fs) begin
                n++;
                checks += 3;
                if (a_idv !== 1'b1) begin errors++;
                    $display("FAIL b2b valid: got %b want 1", a_idv); end
                if (a_pc !== want) begin errors++;
                    $display("FAIL b2b pc: got %h want %h", a_pc, want); end
                if (a_inst !== mem_f(want)) begin errors++;
                    $display("FAIL b2b inst: got %h want %h", a_inst, mem_f(want)); end
                want += 32'd4;
            end
        end
        checks++;
        if (n != 5) begin errors++;
            $display("FAIL b2b rate: got %0d want 5", n); end
        drain();
    endtask

    task automatic test_random();
        int n = 0;
        for (int i = 0; i < 1500; i++) begin
            mem_lat = $urandom_range(1, 4);
            step($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0, 32'($urandom_range(0, 1023)) << 2);
            if (e_commit) n++;
            checks += 6;
            if (s_rv !== e_rv) begin errors++;
                $display("FAIL rnd req_valid @%0d: got %b want %b", cyc, s_rv, e_rv); end
            if (s_fs !== e_fs) begin errors++;
                $display("FAIL rnd fetch_stall @%0d: got %b want %b", cyc, s_fs, e_fs); end
            if (s_addr !== s_pc) begin errors++;
                $display("FAIL rnd addr @%0d: got %h want %h", cyc, s_addr, s_pc); end
            if (a_idv !== e_idv) begin errors++;
                $display("FAIL rnd id_valid @%0d: got %b want %b", cyc, a_idv, e_idv); end
            if (a_pc !== e_pc) begin errors++;
                $display("FAIL rnd id_pc @%0d: got %h want %h", cyc, a_pc, e_pc); end
            if (a_inst !== e_inst) begin errors++;
                $display("FAIL rnd id_inst @%0d: got %h want %h", cyc, a_inst, e_inst); end
        end
        checks++;
        if (n < 50) begin errors++;
            $display("FAIL rnd progress: got %0d commits want >= 50", n); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_decode_stall();
        test_flush_inflight();
        test_flush_coincident();
        test_flush_hold();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
